// File: rtl/control_lectura_escritura.sv
// Read/write slot sequencer between the user-edit logic and the RTC bus engine.
// Each fixed-length bus slot either polls one RTC register or performs one write.
module control_lectura_escritura #(
  parameter int unsigned SLOT_CYCLES = 5120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inistop_crono,
  input  logic [3:0] switch,
  input  logic [7:0] dir_in,
  output logic       camb_hora1,
  output logic       camb_fecha1,
  output logic       camb_crono1,
  output logic       reinicio1,
  output logic       RD_WR,
  output logic [7:0] dir_out
);

  localparam int unsigned CntW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SLOT_CYCLES - 1);

  typedef enum logic [2:0] {
    StRead,
    StWrHora,
    StWrFecha,
    StWrCrono,
    StStartStop,
    StInit
  } mode_e;

  function automatic logic [7:0] read_tbl(input logic [3:0] i);
    case (i)
      4'd0:    read_tbl = 8'h21;
      4'd1:    read_tbl = 8'h22;
      4'd2:    read_tbl = 8'h23;
      4'd3:    read_tbl = 8'h24;
      4'd4:    read_tbl = 8'h25;
      4'd5:    read_tbl = 8'h26;
      4'd6:    read_tbl = 8'h41;
      4'd7:    read_tbl = 8'h42;
      4'd8:    read_tbl = 8'h43;
      default: read_tbl = 8'hF0;
    endcase
  endfunction

  function automatic logic [7:0] init_tbl(input logic [1:0] i);
    case (i)
      2'd0:    init_tbl = 8'h02;
      2'd1:    init_tbl = 8'h10;
      default: init_tbl = 8'h00;
    endcase
  endfunction

  logic [CntW-1:0] cnt_q, cnt_d;
  mode_e           mode_q, mode_d, next_mode;
  logic [3:0]      idx_q, idx_d;
  logic [1:0]      init_idx_q, init_idx_d;
  logic            flag_q, flag_d;
  logic            ino_cur_q, ino_prev_q;
  logic            rd_wr_q, rd_wr_d;
  logic            camb_hora_q, camb_hora_d;
  logic            camb_fecha_q, camb_fecha_d;
  logic            camb_crono_q, camb_crono_d;
  logic            reinicio_q, reinicio_d;
  logic [7:0]      dir_q, dir_d;
  logic            boundary, ino_edge, flag_clr, in_write_edit;

  assign boundary      = (cnt_q == CntLast);
  assign ino_edge      = ino_cur_q & ~ino_prev_q;
  assign in_write_edit = (mode_q == StWrHora) || (mode_q == StWrFecha) || (mode_q == StWrCrono);

  always_comb begin
    if (switch == 4'b1000)      next_mode = StInit;
    else if (flag_q)            next_mode = StStartStop;
    else if (switch == 4'b0001) next_mode = StWrHora;
    else if (switch == 4'b0010) next_mode = StWrFecha;
    else if (switch == 4'b0100) next_mode = StWrCrono;
    else                        next_mode = StRead;
  end

  always_comb begin
    cnt_d        = boundary ? '0 : cnt_q + 1'b1;
    mode_d       = mode_q;
    idx_d        = idx_q;
    init_idx_d   = init_idx_q;
    rd_wr_d      = rd_wr_q;
    camb_hora_d  = camb_hora_q;
    camb_fecha_d = camb_fecha_q;
    camb_crono_d = camb_crono_q;
    reinicio_d   = reinicio_q;
    dir_d        = dir_q;
    flag_clr     = 1'b0;

    if (boundary) begin
      mode_d       = next_mode;
      rd_wr_d      = (next_mode == StRead);
      camb_hora_d  = (next_mode == StWrHora);
      camb_fecha_d = (next_mode == StWrFecha);
      camb_crono_d = (next_mode == StWrCrono);
      reinicio_d   = (next_mode == StInit);
      unique case (next_mode)
        StRead: begin
          dir_d = read_tbl(idx_q);
          idx_d = (idx_q == 4'd9) ? 4'd0 : idx_q + 4'd1;
        end
        StWrHora, StWrFecha, StWrCrono: dir_d = dir_in;
        StStartStop: begin
          dir_d    = 8'h00;
          flag_clr = 1'b1;
        end
        StInit: begin
          if (mode_q != StInit) begin
            dir_d      = init_tbl(2'd0);
            init_idx_d = 2'd1;
          end else begin
            dir_d = init_tbl(init_idx_q);
            if (init_idx_q != 2'd2) init_idx_d = init_idx_q + 2'd1;
          end
        end
        default: dir_d = dir_q;
      endcase
    end else if (in_write_edit) begin
      // Edit modes follow the address from the edit logic within the slot.
      dir_d = dir_in;
    end

    // A fresh edge wins over a simultaneous clear so no request is lost.
    flag_d = ino_edge | (flag_q & ~flag_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      mode_q       <= StRead;
      idx_q        <= 4'd0;
      init_idx_q   <= 2'd0;
      flag_q       <= 1'b0;
      ino_cur_q    <= 1'b0;
      ino_prev_q   <= 1'b0;
      rd_wr_q      <= 1'b1;
      camb_hora_q  <= 1'b0;
      camb_fecha_q <= 1'b0;
      camb_crono_q <= 1'b0;
      reinicio_q   <= 1'b0;
      dir_q        <= 8'h21;
    end else begin
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      init_idx_q   <= init_idx_d;
      flag_q       <= flag_d;
      ino_cur_q    <= inistop_crono;
      ino_prev_q   <= ino_cur_q;
      rd_wr_q      <= rd_wr_d;
      camb_hora_q  <= camb_hora_d;
      camb_fecha_q <= camb_fecha_d;
      camb_crono_q <= camb_crono_d;
      reinicio_q   <= reinicio_d;
      dir_q        <= dir_d;
    end
  end

  assign RD_WR       = rd_wr_q;
  assign camb_hora1  = camb_hora_q;
  assign camb_fecha1 = camb_fecha_q;
  assign camb_crono1 = camb_crono_q;
  assign reinicio1   = reinicio_q;
  assign dir_out     = dir_q;

endmodule

// File: tb/tb_control_lectura_escritura.sv
// Bench for control_lectura_escritura: slot-level reference model plus directed and random scenarios.
module tb_control_lectura_escritura;

  localparam int SLOT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inistop_crono = 1'b0;
  logic [3:0] switch = 4'd0;
  logic [7:0] dir_in = 8'd0;
  logic       camb_hora1, camb_fecha1, camb_crono1, reinicio1, RD_WR;
  logic [7:0] dir_out;

  int total = 0;
  int bad = 0;

  control_lectura_escritura #(.SLOT_CYCLES(SLOT)) dut (
    .clk          (clk),
    .reset        (reset),
    .inistop_crono(inistop_crono),
    .switch       (switch),
    .dir_in       (dir_in),
    .camb_hora1   (camb_hora1),
    .camb_fecha1  (camb_fecha1),
    .camb_crono1  (camb_crono1),
    .reinicio1    (reinicio1),
    .RD_WR        (RD_WR),
    .dir_out      (dir_out)
  );

  always #5 clk = ~clk;

  // Reference model: modes 0=read 1=time 2=date 3=chrono 4=start/stop 5=init.
  logic [7:0] rtbl [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43, 8'hF0};
  logic [7:0] itbl [3]  = '{8'h02, 8'h10, 8'h00};
  int   m_cnt, m_mode, m_ridx, m_istep, nm;
  bit   m_flag, m_cur, m_prev, rise;
  logic [12:0] exp_v;  // {rw, hora, fecha, crono, reinicio, dir}

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0; m_mode = 0; m_ridx = 0; m_istep = 0;
      m_flag = 0; m_cur = 0; m_prev = 0;
      exp_v = {5'b10000, 8'h21};
    end else begin
      rise   = m_cur && !m_prev;
      m_prev = m_cur;
      m_cur  = inistop_crono;
      if (m_cnt == SLOT - 1) begin
        m_cnt = 0;
        if (switch == 4'b1000) nm = 5;
        else if (m_flag) begin nm = 4; m_flag = 0; end
        else if (switch == 4'b0001) nm = 1;
        else if (switch == 4'b0010) nm = 2;
        else if (switch == 4'b0100) nm = 3;
        else nm = 0;
        case (nm)
          0: begin exp_v = {5'b10000, rtbl[m_ridx]}; m_ridx = (m_ridx + 1) % 10; end
          1: exp_v = {5'b01000, dir_in};
          2: exp_v = {5'b00100, dir_in};
          3: exp_v = {5'b00010, dir_in};
          4: exp_v = {5'b00000, 8'h00};
          default: begin
            m_istep = (m_mode == 5) ? m_istep + 1 : 0;
            exp_v = {5'b00001, itbl[(m_istep > 2) ? 2 : m_istep]};
          end
        endcase
        m_mode = nm;
      end else begin
        m_cnt++;
        if (m_mode >= 1 && m_mode <= 3) exp_v[7:0] = dir_in;
      end
      if (rise) m_flag = 1;
    end
  end

  function automatic logic [12:0] act_v();
    return {RD_WR, camb_hora1, camb_fecha1, camb_crono1, reinicio1, dir_out};
  endfunction

  task automatic test_reset();
    reset = 1'b1; switch = 4'd0; inistop_crono = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (act_v() !== {5'b10000, 8'h21}) begin
      bad++; $display("FAIL reset_state got=%h want=%h", act_v(), {5'b10000, 8'h21});
    end
    reset = 1'b0;
  endtask

  task automatic test_read_poll();
    logic [7:0] seq [$];
    logic [7:0] want [12] = '{8'h21, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                              8'h41, 8'h42, 8'h43, 8'hF0, 8'h21};
    for (int i = 0; i < 11 * SLOT; i++) begin
      @(negedge clk);
      if (i == 0 || m_cnt == 0) seq.push_back(dir_out);
      total++;
      if (act_v() !== exp_v || RD_WR !== 1'b1) begin
        bad++; $display("FAIL read_poll cyc=%0d got=%h want=%h", i, act_v(), exp_v);
      end
    end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (i >= seq.size() || seq[i] !== want[i]) begin
        bad++; $display("FAIL read_seq idx=%0d got=%h want=%h", i,
                        (i < seq.size()) ? seq[i] : 8'hxx, want[i]);
      end
    end
  endtask

  task automatic test_write_mode(input logic [3:0] sw, input int slots, input string name);
    logic [7:0] prev_in;
    switch = sw;
    for (int i = 0; i < slots * SLOT; i++) begin
      prev_in = dir_in;
      dir_in = 8'($urandom_range(1, 11));
      @(negedge clk);
      total++;
      if (act_v() !== exp_v) begin
        bad++; $display("FAIL %s cyc=%0d got=%h want=%h", name, i, act_v(), exp_v);
      end
      // Once the mode is active, the address reflects the previous cycle's input.
      if (m_mode != 0 && m_mode != 4 && m_mode != 5) begin
        total++;
        if (dir_out !== dir_in) begin
          bad++; $display("FAIL %s_track cyc=%0d got=%h want=%h", name, i, dir_out, dir_in);
        end
      end
    end
  endtask

  task automatic test_startstop();
    int ss_cycles = 0;
    switch = 4'd0;
    inistop_crono = 1'b1;
    for (int i = 0; i < 6 * SLOT; i++) begin
      if (i == 20) inistop_crono = 1'b0;
      @(negedge clk);
      if (RD_WR === 1'b0 && dir_out === 8'h00) ss_cycles++;
      total++;
      if (act_v() !== exp_v) begin
        bad++; $display("FAIL startstop cyc=%0d got=%h want=%h", i, act_v(), exp_v);
      end
    end
    total++;
    if (ss_cycles != SLOT) begin
      bad++; $display("FAIL startstop_len got=%0d want=%0d", ss_cycles, SLOT);
    end
  endtask

  task automatic test_init();
    logic [7:0] seq [$];
    logic [7:0] want [4] = '{8'h02, 8'h10, 8'h00, 8'h00};
    int ss_after = 0;
    switch = 4'b1000;
    for (int i = 0; i < 7 * SLOT; i++) begin
      inistop_crono = (i >= 10 && i < 14);
      if (i == 5 * SLOT) switch = 4'd0;
      @(negedge clk);
      if (reinicio1 === 1'b1 && m_cnt == 0) seq.push_back(dir_out);
      if (reinicio1 === 1'b0 && RD_WR === 1'b0 && dir_out === 8'h00) ss_after++;
      total++;
      if (act_v() !== exp_v) begin
        bad++; $display("FAIL init cyc=%0d got=%h want=%h", i, act_v(), exp_v);
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= seq.size() || seq[i] !== want[i]) begin
        bad++; $display("FAIL init_seq idx=%0d got=%h want=%h", i,
                        (i < seq.size()) ? seq[i] : 8'hxx, want[i]);
      end
    end
    total++;
    if (ss_after != SLOT) begin
      bad++; $display("FAIL init_deferred_ss got=%0d want=%0d", ss_after, SLOT);
    end
  endtask

  task automatic test_nononehot_reset();
    int guard = 0;
    switch = 4'b0011;
    for (int i = 0; i < 2 * SLOT; i++) begin
      @(negedge clk);
      total++;
      if (act_v() !== exp_v || RD_WR !== 1'b1) begin
        bad++; $display("FAIL nononehot cyc=%0d got=%h want=%h", i, act_v(), exp_v);
      end
    end
    switch = 4'b0001;
    inistop_crono = 1'b1;
    while (!(m_mode == 1 && m_cnt == 3) && guard < 4 * SLOT) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 4 * SLOT) begin
      bad++; $display("FAIL wait_write_slot got=timeout want=write mid-slot");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    inistop_crono = 1'b0;
    switch = 4'd0;
    total++;
    if (act_v() !== {5'b10000, 8'h21}) begin
      bad++; $display("FAIL reset_mid got=%h want=%h", act_v(), {5'b10000, 8'h21});
    end
  endtask

  task automatic test_random();
    logic [3:0] sws [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0110};
    logic [12:0] a;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) switch = sws[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) inistop_crono = ~inistop_crono;
      dir_in = 8'($urandom);
      @(negedge clk);
      a = act_v();
      total++;
      if (a !== exp_v || ($countones(a[11:8]) > 1) || (a[12] && a[11:8] != 4'd0)) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, a, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_poll();
    test_write_mode(4'b0001, 3, "wr_hora");
    test_write_mode(4'b0000, 2, "back_to_read");
    test_write_mode(4'b0010, 2, "wr_fecha");
    test_write_mode(4'b0100, 2, "wr_crono");
    test_startstop();
    test_init();
    test_nononehot_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
